// File: rtl/avmm_regbank_slave.sv
// Avalon-MM register-bank slave with byte-enabled writes,
// programmable read wait states and registered user-side strobes.
module avmm_regbank_slave #(
  parameter int ADDRW   = 8,
  parameter int DATAW   = 32,
  parameter int DEPTH   = 256,
  parameter int RD_WAIT = 1,
  localparam int BEW    = DATAW / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADDRW-1:0] sl_addr,
  input  logic             sl_read,
  input  logic             sl_write,
  input  logic [DATAW-1:0] sl_writedata,
  input  logic [BEW-1:0]   sl_byteenable,
  output logic [DATAW-1:0] sl_readdata,
  output logic             sl_waitrequest,
  output logic [1:0]       sl_response,
  output logic             us_read,
  output logic             us_write,
  output logic             us_cs,
  output logic [ADDRW-1:0] us_addr,
  output logic [BEW-1:0]   us_byteenable
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRW:0] LIM = (ADDRW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RWAIT,
    RACK
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [ADDRW-1:0] r_addr;
  logic [DATAW-1:0] r_rdata;
  logic             r_rerr;
  logic [DATAW-1:0] r_mem [DEPTH];

  logic             w_wreq;
  logic             w_wr_done;
  logic             w_rd_done;
  logic             w_load;
  logic [1:0]       w_resp;
  logic [BEW-1:0]   w_be;
  logic             w_in_rng;
  logic [ADDRW-1:0] w_raddr;
  logic             w_rin_rng;
  logic [IW-1:0]    w_widx;
  logic [IW-1:0]    w_ridx;

  // A byte-wide bus has no lane selects; the single lane is always on.
  assign w_be = (DATAW == 8) ? {BEW{1'b1}} : sl_byteenable;

  assign w_in_rng  = {1'b0, sl_addr} < LIM;
  assign w_raddr   = (r_state == IDLE) ? sl_addr : r_addr;
  assign w_rin_rng = {1'b0, w_raddr} < LIM;
  assign w_widx    = sl_addr[IW-1:0];
  assign w_ridx    = w_raddr[IW-1:0];

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, stall and response decode.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_wreq    = 1'b0;
    w_wr_done = 1'b0;
    w_rd_done = 1'b0;
    w_load    = 1'b0;
    w_resp    = 2'b00;
    unique case (r_state)
      IDLE: begin
        if (sl_write) begin
          w_wr_done = 1'b1;
          if (sl_read || !w_in_rng) begin
            w_resp = 2'b10;
          end
        end else if (sl_read) begin
          w_wreq = 1'b1;
          if (RD_WAIT == 0) begin
            w_next = RACK;
            w_load = 1'b1;
          end else begin
            w_next    = RWAIT;
            w_cnt_nxt = 4'(RD_WAIT);
          end
        end
      end
      RWAIT: begin
        w_wreq = 1'b1;
        if (!sl_read) begin
          w_next    = IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_next = RACK;
            w_load = 1'b1;
          end
        end
      end
      RACK: begin
        w_next = IDLE;
        if (sl_read) begin
          w_rd_done = 1'b1;
          if (r_rerr) begin
            w_resp = 2'b10;
          end
        end else begin
          w_wreq = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
    if (!rst_n) begin
      w_wreq = 1'b1;
    end
  end

  assign sl_waitrequest = w_wreq;
  assign sl_response    = w_resp;
  assign sl_readdata    = w_rd_done ? r_rdata : '0;

  // Capture the read address and the word to return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_rdata <= '0;
      r_rerr  <= 1'b0;
    end else begin
      if (r_state == IDLE && sl_read && !sl_write) begin
        r_addr <= sl_addr;
      end
      if (w_load) begin
        r_rdata <= w_rin_rng ? r_mem[w_ridx] : '0;
        r_rerr  <= !w_rin_rng;
      end
    end
  end

  // Register array with per-lane write enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_done && w_in_rng) begin
      for (int b = 0; b < BEW; b++) begin
        if (w_be[b]) begin
          r_mem[w_widx][8*b +: 8] <= sl_writedata[8*b +: 8];
        end
      end
    end
  end

  // User-side strobes, one cycle after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_read       <= 1'b0;
      us_write      <= 1'b0;
      us_cs         <= 1'b0;
      us_addr       <= '0;
      us_byteenable <= '0;
    end else begin
      us_read  <= w_rd_done;
      us_write <= w_wr_done;
      us_cs    <= w_rd_done | w_wr_done;
      if (w_wr_done) begin
        us_addr       <= sl_addr;
        us_byteenable <= w_be;
      end else if (w_rd_done) begin
        us_addr       <= r_addr;
        us_byteenable <= '0;
      end else begin
        us_addr       <= '0;
        us_byteenable <= '0;
      end
    end
  end

endmodule

// File: tb/tb_avmm_regbank_slave.sv
// Scoreboard bench for avmm_regbank_slave: three instances
// cover RD_WAIT 1/0/15 and DEPTH 256/16.
module tb_avmm_regbank_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a     [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] wd    [3];
  logic [3:0]  be    [3];
  logic [31:0] rdata [3];
  logic        wreq  [3];
  logic [1:0]  resp  [3];
  logic        usr   [3];
  logic        usw   [3];
  logic        uscs  [3];
  logic [7:0]  usa   [3];
  logic [3:0]  usbe  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DP = (g == 1) ? 16 : 256;
    localparam int RW = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    avmm_regbank_slave #(
      .ADDRW(8), .DATAW(32), .DEPTH(DP), .RD_WAIT(RW)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .sl_addr(a[g]),
      .sl_read(rd[g]),
      .sl_write(wr[g]),
      .sl_writedata(wd[g]),
      .sl_byteenable(be[g]),
      .sl_readdata(rdata[g]),
      .sl_waitrequest(wreq[g]),
      .sl_response(resp[g]),
      .us_read(usr[g]),
      .us_write(usw[g]),
      .us_cs(uscs[g]),
      .us_addr(usa[g]),
      .us_byteenable(usbe[g])
    );
  end

  typedef struct {
    int          k;
    bit          chkd;
    logic [31:0] data;
    logic [1:0]  resp;
  } bus_t;

  typedef struct {
    int         k;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [3:0] be;
  } us_t;

  bus_t bq[$];
  us_t  uq[$];
  int errs = 0;
  int checks = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare each completion and each user pulse.
  always @(negedge clk) begin
    bus_t e;
    us_t  u;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if ((rd[k] || wr[k]) && !wreq[k]) begin
          if (bq.size() == 0) begin
            chk("bus_unexpected", 64'(k), 64'hFF);
          end else begin
            e = bq.pop_front();
            chk("bus_dut", 64'(k), 64'(e.k));
            if (e.chkd) chk("rdata", 64'(rdata[k]), 64'(e.data));
            chk("resp", 64'(resp[k]), 64'(e.resp));
          end
        end
        if (uscs[k]) begin
          if (uq.size() == 0) begin
            chk("us_unexpected", 64'(k), 64'hFF);
          end else begin
            u = uq.pop_front();
            chk("us_dut", 64'(k), 64'(u.k));
            chk("us_fields",
                64'({usr[k], usw[k], usa[k], usbe[k]}),
                64'({u.rd, u.wr, u.addr, u.be}));
          end
        end
      end
    end
  end

  task automatic wr_op(int k, logic [7:0] ad, logic [31:0] d,
                       logic [3:0] b, logic also_rd,
                       logic [1:0] er);
    bq.push_back('{k, 1'b0, 32'h0, er});
    uq.push_back('{k, 1'b0, 1'b1, ad, b});
    a[k] = ad; wd[k] = d; be[k] = b;
    wr[k] = 1'b1; rd[k] = also_rd;
    @(negedge clk);
    chk("wr_nowait", 64'(wreq[k]), 64'h0);
    @(posedge clk); #1;
    wr[k] = 1'b0; rd[k] = 1'b0;
  endtask

  task automatic rd_op(int k, logic [7:0] ad, logic [31:0] ed,
                       logic [1:0] er, int ew);
    int n = 0;
    bq.push_back('{k, 1'b1, ed, er});
    uq.push_back('{k, 1'b1, 1'b0, ad, 4'h0});
    a[k] = ad; rd[k] = 1'b1;
    @(negedge clk);
    while (wreq[k] && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("rd_waits", 64'(n), 64'(ew));
    @(posedge clk); #1;
    rd[k] = 1'b0;
  endtask

  task automatic chk_quiet(string nm);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_wreq"}, 64'(wreq[k]), 64'h1);
      chk({nm, "_rdata"}, 64'(rdata[k]), 64'h0);
      chk({nm, "_resp"}, 64'(resp[k]), 64'h0);
      chk({nm, "_us"},
          64'({usr[k], usw[k], uscs[k], usa[k], usbe[k]}),
          64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      a[k] = '0; rd[k] = 0; wr[k] = 0; wd[k] = '0; be[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset asserted while a read sits in RWAIT
    a[0] = 8'h05; rd[0] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    rd[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_op(0, 8'h05, 32'h0, 2'b00, 2);

    // byte lanes and all-zero byteenable
    wr_op(0, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 2'b00);
    wr_op(0, 8'h10, 32'h11223344, 4'h5, 1'b0, 2'b00);
    rd_op(0, 8'h10, 32'hDE22BE44, 2'b00, 2);
    wr_op(0, 8'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 2'b00);
    rd_op(0, 8'h10, 32'hDE22BE44, 2'b00, 2);

    // read and write together
    wr_op(0, 8'h03, 32'h5, 4'hF, 1'b1, 2'b10);
    rd_op(0, 8'h03, 32'h5, 2'b00, 2);

    // abort a read in RWAIT, then a zero-wait write
    a[0] = 8'h07; rd[0] = 1'b1;
    @(posedge clk); #1;
    rd[0] = 1'b0;
    @(posedge clk); #1;
    wr_op(0, 8'h07, 32'h77, 4'hF, 1'b0, 2'b00);
    rd_op(0, 8'h07, 32'h77, 2'b00, 2);

    // DEPTH=16 range boundary, RD_WAIT=0
    wr_op(1, 8'h00, 32'hCAFEF00D, 4'hF, 1'b0, 2'b00);
    wr_op(1, 8'h0F, 32'h0F0F0F0F, 4'hF, 1'b0, 2'b00);
    wr_op(1, 8'h10, 32'h0000BBBB, 4'hF, 1'b0, 2'b10);
    wr_op(1, 8'h20, 32'hAAAAAAAA, 4'hF, 1'b0, 2'b10);
    rd_op(1, 8'h20, 32'h0, 2'b10, 1);
    rd_op(1, 8'h10, 32'h0, 2'b10, 1);
    rd_op(1, 8'h00, 32'hCAFEF00D, 2'b00, 1);
    rd_op(1, 8'h0F, 32'h0F0F0F0F, 2'b00, 1);
    wr_op(1, 8'h01, 32'h11111111, 4'hF, 1'b0, 2'b00);
    wr_op(1, 8'h02, 32'h22222222, 4'hF, 1'b0, 2'b00);
    rd_op(1, 8'h01, 32'h11111111, 2'b00, 1);
    rd_op(1, 8'h02, 32'h22222222, 2'b00, 1);

    // RD_WAIT=15 sweep and top address
    wr_op(2, 8'h01, 32'hA5A5A5A5, 4'hF, 1'b0, 2'b00);
    wr_op(2, 8'h02, 32'h5A5A5A5A, 4'hF, 1'b0, 2'b00);
    rd_op(2, 8'h01, 32'hA5A5A5A5, 2'b00, 16);
    rd_op(2, 8'h02, 32'h5A5A5A5A, 2'b00, 16);
    wr_op(2, 8'hFF, 32'h12345678, 4'h8, 1'b0, 2'b00);
    rd_op(2, 8'hFF, 32'h12000000, 2'b00, 16);

    repeat (4) @(posedge clk);
    #1;
    chk("bq_drained", 64'(bq.size()), 64'h0);
    chk("uq_drained", 64'(uq.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/avmm_regbank_slave.md
# avmm_regbank_slave

Parametrised Avalon-MM register-bank slave: a DEPTH-entry, DATAW-wide register array behind a single MM slave port, with byte-enabled writes, programmable read wait states, an error response for illegal accesses, and registered user-side access strobes. It sits between the MM interconnect and the block's control/status logic and replaces the fixed-width, byteenable-less slave of the previous generation.

## Interface
- ADDRW, 8, word-address width.
- DATAW, 32, data width; legal values 8, 16, 32, 64. BEW = DATAW/8 is derived.
- DEPTH, 256, implemented registers; 1 ≤ DEPTH ≤ 2^ADDRW.
- RD_WAIT, 1, extra read wait states; legal values 0..15.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sl_addr  in  ADDRW  word address.
- sl_read  in  1  read request.
- sl_write  in  1  write request.
- sl_writedata  in  DATAW  write data.
- sl_byteenable  in  BEW  write lane enables; bit i covers bits 8i+7:8i. Tied to 1 internally when DATAW = 8.
- sl_readdata  out  DATAW  read data, valid in the completing cycle.
- sl_waitrequest  out  1  stall; a transfer completes on an edge where a request is high and sl_waitrequest is low.
- sl_response  out  2  00 OKAY, 10 SLVERR; valid in the completing cycle, 00 otherwise.
- us_read  out  1  one-cycle pulse after a completed read.
- us_write  out  1  one-cycle pulse after a completed write.
- us_cs  out  1  us_read | us_write.
- us_addr  out  ADDRW  address of the transfer being pulsed.
- us_byteenable  out  BEW  byteenable of the pulsed write; 0 for reads.

## Operation
- FSM states: IDLE, RWAIT, RACK.
- IDLE, sl_write=1: write completes this cycle (sl_waitrequest=0). If sl_addr < DEPTH, lanes with byteenable=1 are updated at the edge; other lanes are kept; response 00. If sl_addr ≥ DEPTH: nothing is written; response 10.
- IDLE, sl_read=1, sl_write=0: sl_waitrequest=1. Capture the address. Go to RWAIT with the counter loaded to RD_WAIT, or go directly to RACK if RD_WAIT=0.
- RWAIT: sl_waitrequest=1. Decrement the counter. Go to RACK when the counter is 0.
- RACK: sl_waitrequest=0. sl_readdata holds the registered word read from the captured address, or 0 if the address ≥ DEPTH (response 10 in that case). Return to IDLE.
- sl_read and sl_write both high in IDLE: the write is performed as above, the read is ignored, and the response is forced to 10.
- Host drops sl_read in RWAIT or RACK: abort to IDLE. No completion, no us_read pulse.
- Byteenable all-zero write: no register changes, response 00, us_write still pulses.
- Write data is not visible to a read issued in the same cycle as the write; a read issued in the next cycle returns the new data.

## Timing
- Write latency: 0 wait states.
- Read: sl_waitrequest is high for RD_WAIT+1 cycles from the request cycle, and data is returned in cycle RD_WAIT+2.
- sl_waitrequest is combinational from state and sl_read/sl_write. It is forced to 1 while rst_n=0.
- us_* outputs are registered and appear in the cycle after the completing edge. Back-to-back writes give back-to-back pulses.
- Reset (asynchronous, at any point including mid-read):
  - FSM to IDLE, counter 0.
  - All registers 0.
  - sl_readdata 0, sl_response 00.
  - us_read, us_write, us_cs 0; us_addr 0; us_byteenable 0.
  - The read in flight is dropped.
- Address comparison against DEPTH is unsigned and ADDRW wide; no wrap-around.

## Test plan
- Reset then read: assert rst_n=0 mid-RWAIT, release, read addr 0x05 with RD_WAIT=1 -> sl_waitrequest high for 2 cycles, sl_readdata=0x00000000, response 00, us_read pulses once with us_addr=0x05.
- Byte lanes: write 0xDEADBEEF to 0x10 with BE=1111, then 0x11223344 with BE=0101, read 0x10 -> 0xDE22BE44. Follow with a BE=0000 write -> value unchanged, us_write pulses.
- Out of range (DEPTH=16): write 0xAAAAAAAA to 0x20 -> response 10. Read 0x20 -> data 0, response 10. Read 0x00 -> unchanged.
- Collision: sl_read=sl_write=1 at 0x03 with data 0x5 -> write lands, response 10, no read wait, us_write=1, us_read=0.
- Latency sweep: RD_WAIT=0 and RD_WAIT=15, back-to-back reads of 0x01 and 0x02 -> waitrequest high for exactly 1 and 16 cycles per read, correct data each time.
- Abort: drop sl_read during RWAIT -> FSM returns to IDLE, no us_read pulse; the next write completes with 0 wait states.
